board_fill_gen: RTL and testbench

- Parametrised successor to the single-byte LFSR board source for the memory-matrix game.
- Generates a BOARD_W-cell board with exactly `num_lit` lit cells (no more, no fewer), using a free-running 16-bit LFSR that the player or host can reseed.
- Sits in the game datapath between the control FSM (start/done handshake) and the board register / LED / VGA display logic.

---
 rtl/board_fill_gen.sv | 117 +++++++++++
 tb/tb_board_fill_gen.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/board_fill_gen.sv
// board_fill_gen: fills a BOARD_W-cell game board with exactly num_lit lit
// cells. Cell indices come from a free-running, reseedable 16-bit Fibonacci
// LFSR. Indices that are duplicates or out of range are skipped, so a board
// with N lit cells can take more than N fill cycles to finish.
module board_fill_gen #(
  parameter  int BOARD_W = 16,
  localparam int IDX_W   = (BOARD_W > 1) ? $clog2(BOARD_W) : 1,
  localparam int CNT_W   = $clog2(BOARD_W + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               seed_load,
  input  logic [15:0]        seed_in,
  input  logic               start,
  input  logic [CNT_W-1:0]   num_lit,
  output logic [BOARD_W-1:0] board,
  output logic [CNT_W-1:0]   lit_count,
  output logic               busy,
  output logic               done,
  output logic               board_valid
);

  localparam logic [15:0]      LFSR_INIT = 16'hACE1;
  localparam logic [CNT_W-1:0] BOARD_CNT = CNT_W'(BOARD_W);
  localparam logic [IDX_W:0]   BOARD_LIM = (IDX_W + 1)'(BOARD_W);

  typedef enum logic {IDLE, FILL} state_t;

  state_t             state, state_n;
  logic [15:0]        lfsr, lfsr_n;
  logic [CNT_W-1:0]   target, target_n;
  logic [BOARD_W-1:0] board_n;
  logic [CNT_W-1:0]   cnt_n;
  logic               done_n, valid_n;
  logic [IDX_W-1:0]   idx;
  logic               idx_ok;
  logic [CNT_W-1:0]   req_clamped;

  // Taps 16,14,13,11 give a maximal-length sequence, so every cell index
  // shows up eventually and FILL always terminates.
  always_comb begin
    lfsr_n = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  end

  // LFSR register: free-running; a seed load wins over the advance, and an
  // all-zero seed is replaced by the default so the LFSR cannot lock up.
  always_ff @(posedge clk) begin
    if (reset)          lfsr <= LFSR_INIT;
    else if (seed_load) lfsr <= (seed_in == 16'h0000) ? LFSR_INIT : seed_in;
    else                lfsr <= lfsr_n;
  end

  // The candidate cell uses the low LFSR bits from before this edge's
  // advance. The range check matters only when BOARD_W is not a power of two.
  always_comb begin
    idx         = lfsr[IDX_W-1:0];
    idx_ok      = ({1'b0, idx} < BOARD_LIM);
    req_clamped = (num_lit > BOARD_CNT) ? BOARD_CNT : num_lit;
  end

  // Next-state, board update and handshake outputs.
  always_comb begin
    state_n  = state;
    board_n  = board;
    cnt_n    = lit_count;
    target_n = target;
    done_n   = 1'b0;
    valid_n  = board_valid;
    unique case (state)
      IDLE: begin
        if (start) begin
          board_n  = '0;
          cnt_n    = '0;
          target_n = req_clamped;
          valid_n  = 1'b0;
          state_n  = FILL;
        end
      end
      FILL: begin
        if (lit_count == target) begin
          state_n = IDLE;
          done_n  = 1'b1;
          valid_n = 1'b1;
        end else if (idx_ok && !board[idx]) begin
          board_n[idx] = 1'b1;
          cnt_n        = lit_count + CNT_W'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Control and board registers; reset clears everything, even mid-fill.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      board       <= '0;
      lit_count   <= '0;
      target      <= '0;
      done        <= 1'b0;
      board_valid <= 1'b0;
    end else begin
      state       <= state_n;
      board       <= board_n;
      lit_count   <= cnt_n;
      target      <= target_n;
      done        <= done_n;
      board_valid <= valid_n;
    end
  end

  // busy is high for exactly the cycles spent in FILL.
  always_comb begin
    busy = (state == FILL);
  end

endmodule

// File: tb/tb_board_fill_gen.sv
// Testbench for board_fill_gen (BOARD_W = 16). A reference model tracks the
// LFSR and predicts, for each accepted start, which board appears and how
// many edges it takes to finish.
module tb_board_fill_gen;

  localparam int BOARD_W = 16;
  localparam int CNT_W   = 5;

  logic               clk = 1'b0;
  logic               reset = 1'b0;
  logic               seed_load = 1'b0;
  logic [15:0]        seed_in = '0;
  logic               start = 1'b0;
  logic [CNT_W-1:0]   num_lit = '0;
  logic [BOARD_W-1:0] board;
  logic [CNT_W-1:0]   lit_count;
  logic               busy, done, board_valid;

  int          vectors = 0;
  int          miscompares = 0;
  logic [15:0] m_lfsr = 16'hACE1;

  board_fill_gen #(.BOARD_W(BOARD_W)) dut (
    .clk(clk), .reset(reset), .seed_load(seed_load), .seed_in(seed_in),
    .start(start), .num_lit(num_lit), .board(board), .lit_count(lit_count),
    .busy(busy), .done(done), .board_valid(board_valid)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] lfsr_step(input logic [15:0] l);
    return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
  endfunction

  // Update the model LFSR from the inputs about to be sampled, then take one
  // edge and settle past it.
  task automatic step();
    if (reset)          m_lfsr = 16'hACE1;
    else if (seed_load) m_lfsr = (seed_in == 16'h0) ? 16'hACE1 : seed_in;
    else                m_lfsr = lfsr_step(m_lfsr);
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Draw indices from the LFSR stream until tgt distinct cells are lit.
  task automatic predict(input logic [15:0] l0, input int tgt,
                         output logic [15:0] b, output int edges);
    logic [15:0] l = l0;
    int cnt = 0;
    b = '0;
    edges = 0;
    while (cnt < tgt) begin
      if (!b[l[3:0]]) begin
        b[l[3:0]] = 1'b1;
        cnt++;
      end
      l = lfsr_step(l);
      edges++;
    end
  endtask

  // Accept a start, then follow FILL to completion. If nl2 >= 0, start is
  // pulsed again with num_lit = nl2 on the first FILL edge; it must be ignored.
  task automatic run_board(input int nl, input int nl2);
    logic [15:0] exp_b;
    int pe, tgt, e;
    bit seen;
    tgt = (nl > BOARD_W) ? BOARD_W : nl;
    start = 1'b1;
    num_lit = CNT_W'(nl);
    step();
    start = 1'b0;
    chk("start_board_clr", board, 0);
    chk("start_cnt_clr", lit_count, 0);
    chk("start_busy", busy, 1);
    chk("start_valid_clr", board_valid, 0);
    chk("start_done_low", done, 0);
    predict(m_lfsr, tgt, exp_b, pe);
    seen = 0;
    e = 0;
    while (!seen && e < 2000) begin
      if (e == 0 && nl2 >= 0) begin
        start = 1'b1;
        num_lit = CNT_W'(nl2);
      end
      step();
      start = 1'b0;
      e++;
      chk("popcount_inv", lit_count, $countones(board));
      if (done) seen = 1;
    end
    chk("done_seen", seen, 1);
    chk("latency", e, pe + 1);
    chk("final_board", board, exp_b);
    chk("final_count", lit_count, tgt);
    chk("final_busy", busy, 0);
    chk("final_valid", board_valid, 1);
    step();
    chk("done_one_cycle", done, 0);
    chk("valid_held", board_valid, 1);
    chk("board_held", board, exp_b);
  endtask

  initial begin
    int cyc;
    // Reset
    reset = 1'b1;
    step();
    step();
    chk("rst_board", board, 0);
    chk("rst_count", lit_count, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_valid", board_valid, 0);
    reset = 1'b0;

    // From ACE1: start advances to 59C3, cells come from 59C3 and B387.
    run_board(2, -1);
    chk("ace1_board", board, 16'h0088);

    // Seed 0001, three cells at indices 2, 4, 8.
    seed_load = 1'b1; seed_in = 16'h0001; step(); seed_load = 1'b0;
    run_board(3, -1);
    chk("det_board", board, 16'h0114);

    // Zero target and clamp.
    run_board(0, -1);
    chk("zero_board", board, 0);
    run_board(20, -1);
    chk("clamp_board", board, 16'hFFFF);
    chk("clamp_count", lit_count, 16);

    // Zero seed reloads ACE1: cells 3, 7, 15.
    seed_load = 1'b1; seed_in = 16'h0000; step(); seed_load = 1'b0;
    run_board(3, -1);
    chk("seed0_board", board, 16'h8088);

    // Restart mid-FILL is ignored; the following IDLE start clears the old
    // board (checked inside run_board on the start edge).
    seed_load = 1'b1; seed_in = 16'h5A5A; step(); seed_load = 1'b0;
    run_board(5, 12);
    chk("restart_ignored_cnt", lit_count, 5);
    run_board(7, -1);

    // Reset in the middle of FILL after two cells are lit.
    seed_load = 1'b1; seed_in = 16'h1234; step(); seed_load = 1'b0;
    start = 1'b1; num_lit = 5'd8; step(); start = 1'b0;
    cyc = 0;
    while (lit_count != 2 && cyc < 200) begin
      step();
      cyc++;
    end
    chk("mid_two_cells", lit_count, 2);
    reset = 1'b1; step(); reset = 1'b0;
    chk("mid_rst_board", board, 0);
    chk("mid_rst_count", lit_count, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_valid", board_valid, 0);
    run_board(4, -1);

    // Random seeds and requested counts.
    for (int i = 0; i < 200; i++) begin
      seed_load = 1'b1;
      seed_in = 16'($urandom);
      step();
      seed_load = 1'b0;
      run_board(int'($urandom_range(0, 31)), -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
